mmvfsg_seq: RTL
===============

MMVFSG_SEQ -- requirements
Module: mmvfsg_seq

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL have parameter DEPTH, default 8, giving the number of program table entries (power of 2, 2..16).
REQ-003 SHALL have parameter PRESCALE, default 10000, giving clk cycles per dwell tick (1 ms at 10 MHz).
REQ-004 SHALL have port clk, input, 1 bit: clock.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port wr_en, input, 1 bit: table write strobe.
REQ-007 SHALL have port wr_addr, input, log2(DEPTH) bits: table entry index.
REQ-008 SHALL have port wr_data, input, 16 bits: {mode[15:12], freq[11:8], dwell[7:0]}.
REQ-009 SHALL have port start, input, 1 bit: begin the program at entry 0.
REQ-010 SHALL have port stop, input, 1 bit: abort the program.
REQ-011 SHALL have port mode_out, output, 4 bits: drives the signal generator's mode input.
REQ-012 SHALL have port freq_out, output, 4 bits: drives the signal generator's freq input.
REQ-013 SHALL have port busy, output, 1 bit: high while the program runs.
REQ-014 SHALL have port step_idx, output, log2(DEPTH) bits: index of the active entry.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse at program end.

Function
REQ-016 SHALL hold DEPTH table entries in registers; a write with wr_en=1 updates the entry at the next clock edge, in any state.
REQ-017 SHALL implement the states IDLE, RUN and DONE.
REQ-018 In IDLE, start=1 (with stop=0) SHALL load entry 0 at the next edge: mode_out, freq_out, step_idx=0, busy=1, dwell counter=dwell, prescaler cleared, state RUN.
REQ-019 SHALL treat an entry with dwell=0 as the end-of-program marker; it is never output.
REQ-020 In RUN, each entry SHALL be held for exactly dwell*PRESCALE clk cycles before the next entry appears on mode_out/freq_out.
REQ-021 SHALL advance step_idx by 1 and load the next entry in the same edge where the current dwell expires.
REQ-022 SHALL end the program when the next entry has dwell=0, or when step_idx=DEPTH-1 expires.
REQ-023 At program end: done=1 for one cycle, busy=0, mode_out=0, freq_out=0, state DONE, then IDLE on the following cycle.
REQ-024 A start that hits a dwell=0 entry 0 SHALL produce done one cycle later and SHALL NOT assert busy.
REQ-025 stop=1 in any state SHALL return to IDLE at the next edge with mode_out=0, freq_out=0, busy=0, step_idx=0, and no done pulse.
REQ-026 stop SHALL win over a simultaneous start.
REQ-027 start in RUN or DONE SHALL be ignored.
REQ-028 A table write to the active entry SHALL NOT alter current outputs; it takes effect on the next load of that entry.
REQ-029 Dwell and prescaler counters SHALL never wrap; the prescaler counts 0..PRESCALE-1.

Reset
REQ-030 rst=1 SHALL force state IDLE, all outputs 0, and prescaler and dwell counter 0; table contents SHALL be cleared to 0.
REQ-031 rst mid-RUN SHALL behave as REQ-030 with no done pulse.

Configuration
REQ-032 SHALL use macro MMVFSG_SEQ_LOOP_EN. When defined, the program end (REQ-022) reloads entry 0 instead of entering DONE; busy stays 1 and done pulses for one cycle per wrap. The exception is a dwell=0 entry 0, which still ends as in REQ-024.
REQ-033 Without MMVFSG_SEQ_LOOP_EN, the program SHALL run once as in REQ-023.

Structure
REQ-034 Package mmvfsg_pkg SHALL hold the state enum, the entry field widths/offsets, and the mode constants MODE_OFF=0, MODE_RAMP=1, MODE_SAW=2, MODE_SQUARE=4.
REQ-035 SHALL instantiate sub-module mmvfsg_tick, a PRESCALE-cycle tick generator with synchronous clear.

Verification (PRESCALE=4, DEPTH=8)
REQ-036 Program {0x1305, 0x2102, 0x0000}, start -> mode/freq 1/3 for 20 cycles, then 2/1 for 8 cycles, then done pulse, busy=0, outputs 0.
REQ-037 All 8 entries with dwell=1, start -> step_idx 0..7 at 4-cycle spacing, done after entry 7.
REQ-038 stop asserted mid-entry 1 -> next cycle IDLE, outputs 0, no done; start together with stop in IDLE -> stays IDLE.
REQ-039 Entry 0 dwell=0, start -> done one cycle later, busy never 1.
REQ-040 With MMVFSG_SEQ_LOOP_EN, program {0x4001, 0x0000} -> mode 4 held continuously, done every 4 cycles, busy stays 1.
REQ-041 rst asserted during RUN -> all outputs 0 next cycle; subsequent start with an empty table -> immediate done.

Source files
------------

// File: rtl/mmvfsg_pkg.sv
// mmvfsg_pkg: shared definitions for the mmvfsg_seq signal-generator sequencer.
//   - program table entry layout {mode[15:12], freq[11:8], dwell[7:0]}
//   - signal-generator mode constants
//   - sequencer state encoding (plain localparams so that legacy tools can consume it)
package mmvfsg_pkg;

  // Entry field widths and bit offsets inside the 16-bit table word.
  localparam int unsigned EntryW   = 16;
  localparam int unsigned ModeW    = 4;
  localparam int unsigned FreqW    = 4;
  localparam int unsigned DwellW   = 8;
  localparam int unsigned ModeLsb  = 12;
  localparam int unsigned FreqLsb  = 8;
  localparam int unsigned DwellLsb = 0;

  typedef struct packed {
    logic [ModeW-1:0]  mode;
    logic [FreqW-1:0]  freq;
    logic [DwellW-1:0] dwell;
  } entry_t;

  // Signal-generator mode codes.
  localparam logic [ModeW-1:0] MODE_OFF    = 4'd0;
  localparam logic [ModeW-1:0] MODE_RAMP   = 4'd1;
  localparam logic [ModeW-1:0] MODE_SAW    = 4'd2;
  localparam logic [ModeW-1:0] MODE_SQUARE = 4'd4;

  // Sequencer states.
  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

  // Split a raw table word into its fields.
  function automatic entry_t unpack_entry(logic [EntryW-1:0] raw);
    entry_t e;
    e.mode  = raw[ModeLsb  +: ModeW];
    e.freq  = raw[FreqLsb  +: FreqW];
    e.dwell = raw[DwellLsb +: DwellW];
    return e;
  endfunction

endpackage

// File: rtl/mmvfsg_seq_if.sv
// mmvfsg_seq_if: table-write, control and generator-drive signals of mmvfsg_seq.
//   master : table writer / controller (drives wr_*, start, stop)
//   slave  : the sequencer (drives mode_out, freq_out, busy, step_idx, done)
// Parameter DEPTH must match the sequencer's DEPTH (sets wr_addr/step_idx width).
interface mmvfsg_seq_if #(
  parameter int unsigned DEPTH = 8
) ();
  localparam int unsigned AW = $clog2(DEPTH);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          start;
  logic          stop;
  logic [3:0]    mode_out;
  logic [3:0]    freq_out;
  logic          busy;
  logic [AW-1:0] step_idx;
  logic          done;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop,
    input  mode_out, freq_out, busy, step_idx, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop,
    output mode_out, freq_out, busy, step_idx, done
  );

endinterface

// File: rtl/mmvfsg_tick.sv
// mmvfsg_tick: prescaler producing one tick every PRESCALE enabled clk cycles.
//   clk    : clock
//   rst    : synchronous active-high reset (counter to 0)
//   clr_i  : synchronous clear, counter to 0, suppresses the tick
//   en_i   : count enable
//   tick_o : high in the cycle where the counter sits at PRESCALE-1
// The counter runs 0..PRESCALE-1 and returns to 0; it never wraps past that.
module mmvfsg_tick #(
  parameter int unsigned PRESCALE = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] Last = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i & ~clr_i & (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mmvfsg_seq.sv
// mmvfsg_seq: programmable step sequencer driving a signal generator's mode/freq inputs.
// A DEPTH-entry register table holds {mode, freq, dwell}. On start the entries are played
// from index 0, each held for dwell*PRESCALE clk cycles; a dwell of 0 marks program end.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (state, outputs, counters and table cleared)
//   bus  : mmvfsg_seq_if.slave
//          wr_en/wr_addr/wr_data : table write, takes effect next edge in any state
//          start/stop            : begin at entry 0 / abort (stop wins)
//          mode_out/freq_out     : active entry fields, 0 when not running
//          busy/step_idx/done    : running flag, active index, one-cycle end pulse
// Build option: define MMVFSG_SEQ_LOOP_EN to replay from entry 0 at program end instead of
// stopping; done then pulses once per wrap while busy stays high.
module mmvfsg_seq
  import mmvfsg_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PRESCALE = 10000
) (
  input  logic         clk,
  input  logic         rst,
  mmvfsg_seq_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  // Program table.
  entry_t tbl_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (bus.wr_en) begin
      tbl_q[bus.wr_addr] <= unpack_entry(bus.wr_data);
    end
  end

  // Sequencer state and registered outputs. Outputs are copies taken at load time, so a
  // table write to the active entry only shows on its next load.
  state_t            state_q, state_d;
  logic [ModeW-1:0]  mode_q, mode_d;
  logic [FreqW-1:0]  freq_q, freq_d;
  logic              busy_q, busy_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic              done_q, done_d;

  logic    tick;
  logic    tick_clr;
  logic    load_en;
  logic    end_en;
  logic [AW-1:0] load_idx;
  logic [AW-1:0] next_idx;
  entry_t  e0;
  entry_t  nxt;
  entry_t  ld;

  // Prescaler only runs in RUN; it is held at 0 elsewhere so every load starts a fresh
  // dwell period. Within RUN it rolls over to 0 exactly on the expiring tick.
  assign tick_clr = (state_q != StRun) | bus.stop;

  mmvfsg_tick #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tick_clr),
    .en_i   (state_q == StRun),
    .tick_o (tick)
  );

  assign next_idx = idx_q + 1'b1;
  assign e0       = tbl_q[0];
  assign nxt      = tbl_q[next_idx];

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    freq_d   = freq_q;
    busy_d   = busy_q;
    idx_d    = idx_q;
    dwell_d  = dwell_q;
    done_d   = 1'b0;
    load_en  = 1'b0;
    end_en   = 1'b0;
    load_idx = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          // An empty entry 0 ends immediately without ever raising busy.
          if (e0.dwell == '0) begin
            end_en = 1'b1;
          end else begin
            load_en = 1'b1;
          end
        end
      end
      StRun: begin
        if (tick) begin
          if (dwell_q > 8'd1) begin
            dwell_d = dwell_q - 8'd1;
          end else if ((idx_q == LastIdx) || (nxt.dwell == '0)) begin
`ifdef MMVFSG_SEQ_LOOP_EN
            done_d = 1'b1;
            if (e0.dwell != '0) begin
              load_en = 1'b1;
            end else begin
              end_en = 1'b1;
            end
`else
            end_en = 1'b1;
`endif
          end else begin
            load_en  = 1'b1;
            load_idx = next_idx;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ld = tbl_q[load_idx];
    if (load_en) begin
      state_d = StRun;
      mode_d  = ld.mode;
      freq_d  = ld.freq;
      busy_d  = 1'b1;
      idx_d   = load_idx;
      dwell_d = ld.dwell;
    end

    if (end_en) begin
      state_d = StDone;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      mode_d  = MODE_OFF;
      freq_d  = '0;
      idx_d   = '0;
      dwell_d = '0;
    end

    // Abort overrides everything, including a same-cycle start or program end.
    if (bus.stop) begin
      state_d = StIdle;
      done_d  = 1'b0;
      busy_d  = 1'b0;
      mode_d  = MODE_OFF;
      freq_d  = '0;
      idx_d   = '0;
      dwell_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= MODE_OFF;
      freq_q  <= '0;
      busy_q  <= 1'b0;
      idx_q   <= '0;
      dwell_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      freq_q  <= freq_d;
      busy_q  <= busy_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      done_q  <= done_d;
    end
  end

  assign bus.mode_out = mode_q;
  assign bus.freq_out = freq_q;
  assign bus.busy     = busy_q;
  assign bus.step_idx = idx_q;
  assign bus.done     = done_q;

endmodule
